// File: rtl/pipelined_chunk_adder.sv
// Add/subtract unit split into CHUNK-bit ripple stages. Each stage has its own
// valid bit and advances whenever the stage below it is free, so bubbles collapse.
module pipelined_chunk_adder #(
   parameter  int WIDTH  = 16,
   parameter  int CHUNK  = 4,
   localparam int STAGES = WIDTH / CHUNK
) (
   input  logic              Clk,
   input  logic              rstN,
   input  logic              inValid,
   output logic              inReady,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              cIn,
   input  logic              sub,
   output logic              outValid,
   input  logic              outReady,
   output logic [WIDTH-1:0]  sum,
   output logic              cOut,
   output logic              ovf,
   output logic [STAGES-1:0] chunkCarry
);

   if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("WIDTH must be a positive integer multiple of CHUNK");
   end

   logic [STAGES-1:0] vld, adv, load, c_q, ci_src;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [STAGES-1:0] cc_q [STAGES];
   logic [WIDTH-1:0]  a_src [STAGES];
   logic [WIDTH-1:0]  b_src [STAGES];
   logic [WIDTH-1:0]  ps_src [STAGES];
   logic [WIDTH-1:0]  nxt_sum [STAGES];
   logic [STAGES-1:0] pc_src [STAGES];
   logic [STAGES-1:0] nxt_cc [STAGES];
   logic [CHUNK:0]    part [STAGES];

   // Walk from the output back to stage 0: a stage may move on when the one
   // below it is empty or is itself moving on this cycle.
   always_comb begin
      logic take;
      adv  = '0;
      take = outReady;
      for (int k = STAGES - 1; k >= 0; k--) begin
         adv[k] = vld[k] & take;
         take   = ~vld[k] | adv[k];
      end
   end

   assign inReady = rstN & (~vld[0] | adv[0]);

   always_comb begin
      load    = adv << 1;
      load[0] = inValid & inReady;
   end

   // Stage 0 sees the raw operands with subtract folded into ~b / ~cIn;
   // later stages see the skewed copies registered by the stage above.
   always_comb begin
      a_src[0]  = a;
      b_src[0]  = sub ? ~b : b;
      ci_src[0] = sub ^ cIn;
      ps_src[0] = '0;
      pc_src[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         a_src[k]  = a_q[k-1];
         b_src[k]  = b_q[k-1];
         ci_src[k] = c_q[k-1];
         ps_src[k] = sum_q[k-1];
         pc_src[k] = cc_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         part[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                 + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, ci_src[k]};
         nxt_sum[k] = ps_src[k];
         nxt_sum[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
         nxt_cc[k]    = pc_src[k];
         nxt_cc[k][k] = part[k][CHUNK];
      end
   end

   always_ff @(posedge Clk or negedge rstN) begin
      if (!rstN) begin
         vld <= '0;
         c_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
            cc_q[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
               a_q[k]   <= a_src[k];
               b_q[k]   <= b_src[k];
               sum_q[k] <= nxt_sum[k];
               cc_q[k]  <= nxt_cc[k];
               c_q[k]   <= part[k][CHUNK];
            end
            vld[k] <= load[k] | (vld[k] & ~adv[k]);
         end
      end
   end

   assign outValid   = vld[STAGES-1];
   assign sum        = sum_q[STAGES-1];
   assign cOut       = c_q[STAGES-1];
   assign chunkCarry = cc_q[STAGES-1];
   // Carry into the MSB is recovered from the MSB operand bits and sum bit.
   assign ovf = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
              ^ sum_q[STAGES-1][WIDTH-1] ^ c_q[STAGES-1];

endmodule

// File: doc/pipelined_chunk_adder.md
PIPELINED_CHUNK_ADDER -- requirements
Module: pipelined_chunk_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK SHALL be at least 1.
REQ-003 The block SHALL derive STAGES = WIDTH/CHUNK internally; STAGES is not overridable.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port rstN, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port inValid, input, 1 bit: the upstream operand set is valid.
REQ-007 The block SHALL have port inReady, output, 1 bit: the block can accept an operand set this cycle.
REQ-008 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-009 The block SHALL have port cIn, input, 1 bit: carry-in for add, borrow-in for subtract.
REQ-010 The block SHALL have port sub, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-011 The block SHALL have port outValid, output, 1 bit: the result is valid.
REQ-012 The block SHALL have port outReady, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-014 The block SHALL have port cOut, output, 1 bit: carry out of the MSB.
REQ-015 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-016 The block SHALL have port chunkCarry, output, STAGES bits: chunkCarry[k] is the carry out of chunk k.

Function
REQ-017 Transfers SHALL occur only on rising Clk edges: input on inValid && inReady, output on outValid && outReady.
REQ-018 For add, the block SHALL compute {cOut,sum} = a + b + cIn, modulo 2^(WIDTH+1).
REQ-019 For subtract, the block SHALL use b' = ~b and carry-in = ~cIn, giving sum = a - b - cIn, with cOut=1 meaning no borrow.
REQ-020 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-021 Stage k SHALL add chunk k, bits [k*CHUNK +: CHUNK], using the registered carry from stage k-1 (stage 0 uses the effective carry-in).
REQ-022 Unprocessed upper operand chunks, completed lower sum chunks, and chunk carries SHALL be carried forward in skewed registers.
REQ-023 Each stage SHALL hold its own valid bit; stage k SHALL load when its upstream is valid and stage k is either empty or transferring downstream in the same cycle, so bubbles collapse.
REQ-024 The last stage SHALL be the output register, driving sum, cOut, ovf, chunkCarry and outValid.
REQ-025 Latency SHALL be exactly STAGES cycles from input transfer to outValid when there is no backpressure.
REQ-026 Throughput SHALL be one transaction per cycle when outReady=1.
REQ-027 inReady SHALL be combinational: 1 when stage 0 is empty or stage 0 advances this cycle.
REQ-028 Capacity SHALL be STAGES transactions; when all stages are full and outReady=0, inReady SHALL be 0.
REQ-029 While outValid=1 and outReady=0, all outputs SHALL hold stable.
REQ-030 Results SHALL emerge in input order with no loss or duplication.
REQ-031 Simultaneous input and output transfers on a full pipe SHALL both complete in the same cycle.
REQ-032 When STAGES=1 (CHUNK=WIDTH), the block SHALL behave as a single registered adder with latency 1.
REQ-033 The sub and cIn values SHALL be captured per transaction; changing them while a transaction is in flight SHALL not affect that transaction.

Reset
REQ-034 While rstN=0, every stage valid bit SHALL clear, outValid=0, sum=0, cOut=0, ovf=0, chunkCarry=0, and inReady=0.
REQ-035 Reset SHALL take effect immediately, without waiting for Clk; in-flight transactions SHALL be discarded and never emitted.
REQ-036 inReady SHALL be 1 in the first cycle after rstN rises.

Verification (WIDTH=16, CHUNK=4 unless noted)
REQ-037 a=16'h00FF, b=16'h0001, cIn=0, sub=0 -> 4 cycles later sum=16'h0100, cOut=0, ovf=0, chunkCarry=4'b0011.
REQ-038 a=16'hFFFF, b=16'hFFFF, cIn=1, sub=0 -> sum=16'hFFFF, cOut=1, ovf=0, chunkCarry=4'b1111.
REQ-039 a=16'h8000, b=16'h0001, cIn=0, sub=1 -> sum=16'h7FFF, cOut=1, ovf=1, chunkCarry=4'b1000.
REQ-040 Backpressure: stream 8 back-to-back transactions with outReady=0 for 8 cycles -> inReady=0 once 4 are held; on release, all 8 results appear in order, none lost or duplicated.
REQ-041 Reset mid-operation: 2 transactions in flight, rstN pulsed low between edges -> outValid drops immediately, and no stale result appears after release.
REQ-042 WIDTH=8, CHUNK=8: a=8'h7F, b=8'h01, add -> one cycle later sum=8'h80, cOut=0, ovf=1.
